tcnt_axi_rd_arbiter: RTL
========================

TCNT_AXI_RD_ARBITER -- requirements
Module: tcnt_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of upstream AXI read requesters; power of two, 2..8.
REQ-002 SHALL have parameter ID_W, default 4: upstream ARID/RID width.
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have parameter DATA_W, default 64: read data width.
REQ-005 SHALL have parameter MAX_OUT, default 8: per-requester outstanding-burst cap; derived IDX_W = clog2(NUM_REQ).
REQ-006 SHALL have port aclk  in  1: single clock; all logic rising-edge.
REQ-007 SHALL have port aresetn  in  1: asynchronous active-low reset.
REQ-008 SHALL have ports s_arvalid in NUM_REQ, s_arready out NUM_REQ: per-requester AR handshake.
REQ-009 SHALL have ports s_araddr in NUM_REQ*ADDR_W, s_arlen in NUM_REQ*8, s_arsize in NUM_REQ*3, s_arburst in NUM_REQ*2, s_arid in NUM_REQ*ID_W: packed per-requester AR payload; slice i belongs to requester i.
REQ-010 SHALL have ports m_arvalid out 1, m_arready in 1, m_araddr out ADDR_W, m_arlen out 8, m_arsize out 3, m_arburst out 2, m_arid out ID_W+IDX_W: downstream AR.
REQ-011 SHALL have ports m_rvalid in 1, m_rready out 1, m_rdata in DATA_W, m_rresp in 2, m_rlast in 1, m_rid in ID_W+IDX_W: downstream R.
REQ-012 SHALL have ports s_rvalid out NUM_REQ, s_rready in NUM_REQ, s_rdata out DATA_W, s_rresp out 2, s_rlast out 1, s_rid out ID_W: upstream R; data/resp/last/id broadcast to all requesters.
REQ-013 SHALL have port err_unexpected_r  out 1: sticky flag for an R beat routed to a requester with zero outstanding bursts.

Function
REQ-014 SHALL implement AR FSM with states IDLE and HOLD.
REQ-015 In IDLE, eligible = s_arvalid[i] and outstanding[i] < MAX_OUT; if any eligible, SHALL pick winner by round-robin starting at rr_ptr, assert s_arready[winner] combinationally that cycle, register payload into m_ar*, and go to HOLD.
REQ-016 Registered m_arid SHALL be {winner index, s_arid[winner]}; index in upper IDX_W bits.
REQ-017 In HOLD, m_arvalid SHALL be 1 and m_ar* SHALL stay stable; all s_arready SHALL be 0; on m_arready=1, go to IDLE next cycle.
REQ-018 Throughput: at most one AR every 2 cycles; s_arready-to-m_arvalid latency exactly 1 cycle.
REQ-019 On each grant, rr_ptr SHALL become (winner+1) mod NUM_REQ; unchanged when no grant.
REQ-020 Requester at MAX_OUT SHALL be skipped without stalling others.
REQ-021 outstanding[i] SHALL increment at the grant cycle and decrement on m_rvalid & m_rready & m_rlast with m_rid index = i; simultaneous increment and decrement SHALL leave it unchanged.
REQ-022 R path SHALL be combinational, zero latency: idx = m_rid upper IDX_W bits; s_rvalid[idx] = m_rvalid, others 0; m_rready = s_rready[idx]; s_rid = m_rid lower ID_W bits; s_rdata/s_rresp/s_rlast = m_r* pass-through.
REQ-023 An R last-beat handshake with outstanding[idx]=0 SHALL set err_unexpected_r and SHALL NOT decrement (no underflow).
REQ-024 Counters SHALL be clog2(MAX_OUT+1) bits and never exceed MAX_OUT.

Reset
REQ-025 On aresetn=0, asynchronously: FSM=IDLE, rr_ptr=0, all outstanding=0, m_arvalid=0, m_ar* payload=0, err_unexpected_r=0.
REQ-026 Reset mid-HOLD SHALL drop m_arvalid immediately; pending burst is discarded, not replayed.
REQ-027 err_unexpected_r SHALL be cleared only by reset.

Structure
REQ-028 AXI field widths (len 8, size 3, burst 2, resp 2) SHALL be constants in shared package tcnt_axi_arb_pkg, together with the FSM state enum.
REQ-029 Round-robin picker SHALL be sub-module tcnt_rr_picker (inputs eligible vector and rr_ptr, outputs winner one-hot, index, and any-valid).

Verification
REQ-030 Reset, then s_arvalid=4'b1111, m_arready=1 constant -> grants in order 0,1,2,3,0, one every 2 cycles; m_arid upper bits 0,1,2,3,0.
REQ-031 Req 2 issues ARID=5, araddr=0x1000, arlen=3; m_arready held 0 for 5 cycles -> m_ar* stable 5 cycles, m_arid=0x25, then IDLE.
REQ-032 Req 1 issues 8 bursts without R -> 9th request not granted, req 3 still granted; one rlast for req 1 -> req 1 granted again.
REQ-033 m_rid=0x37, rlast=1, s_rready[3]=0 -> s_rvalid=4'b1000, m_rready=0, s_rid=7; then s_rready[3]=1 -> outstanding[3] decrements by 1.
REQ-034 R last beat with m_rid index 0 and outstanding[0]=0 -> err_unexpected_r=1 next cycle, stays 1 until aresetn=0.
REQ-035 Grant and last-beat for the same requester in the same cycle -> outstanding unchanged; aresetn=0 during HOLD -> m_arvalid=0 without clock edge.

Source files
------------

// File: rtl/tcnt_axi_arb_pkg.sv
// Shared constants and types for the AXI read arbiter.
// Contents:
//   AXI_*_W     AXI read-channel field widths
//   ar_state_e  AR-side FSM state
package tcnt_axi_arb_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ar_state_e;

endpackage

// File: rtl/tcnt_rr_picker.sv
// Round-robin picker: the first eligible requester found when searching
// upward from rr_ptr, wrapping at NUM_REQ.
// Ports:
//   eligible   in  NUM_REQ  requesters allowed to win this cycle
//   rr_ptr     in  IDX_W    index with the highest priority
//   win_oh     out NUM_REQ  one-hot winner (zero when none eligible)
//   win_idx    out IDX_W    winner index
//   any_valid  out 1        at least one requester is eligible
module tcnt_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any_valid
);

    logic [IDX_W-1:0] cand;

    // NUM_REQ is a power of two, so IDX_W-bit addition wraps naturally.
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!any_valid && eligible[cand]) begin
                any_valid     = 1'b1;
                win_idx       = cand;
                win_oh[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcnt_axi_rd_arbiter.sv
// N:1 AXI read arbiter. AR requests are arbitrated round-robin, tagged with
// the requester index in the upper ARID bits and held in a register slice
// until accepted downstream. R beats are steered back combinationally by
// the RID tag. A per-requester counter caps outstanding bursts at MAX_OUT.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   s_ar*                  packed per-requester AR channels (slice i = req i)
//   m_ar*                  downstream AR, m_arid = {req index, s_arid}
//   m_r*                   downstream R
//   s_r*                   upstream R; payload broadcast, s_rvalid one-hot
//   err_unexpected_r       sticky: last beat for a requester with nothing outstanding
module tcnt_axi_rd_arbiter
    import tcnt_axi_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  ID_W    = 4,
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 64,
    parameter int  MAX_OUT = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_REQ-1:0]          s_arvalid,
    output logic [NUM_REQ-1:0]          s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0]   s_araddr,
    input  logic [NUM_REQ*8-1:0]        s_arlen,
    input  logic [NUM_REQ*3-1:0]        s_arsize,
    input  logic [NUM_REQ*2-1:0]        s_arburst,
    input  logic [NUM_REQ*ID_W-1:0]     s_arid,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [ADDR_W-1:0]           m_araddr,
    output logic [AXI_LEN_W-1:0]        m_arlen,
    output logic [AXI_SIZE_W-1:0]       m_arsize,
    output logic [AXI_BURST_W-1:0]      m_arburst,
    output logic [ID_W+IDX_W-1:0]       m_arid,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic [AXI_RESP_W-1:0]       m_rresp,
    input  logic                        m_rlast,
    input  logic [ID_W+IDX_W-1:0]       m_rid,
    output logic [NUM_REQ-1:0]          s_rvalid,
    input  logic [NUM_REQ-1:0]          s_rready,
    output logic [DATA_W-1:0]           s_rdata,
    output logic [AXI_RESP_W-1:0]       s_rresp,
    output logic                        s_rlast,
    output logic [ID_W-1:0]             s_rid,
    output logic                        err_unexpected_r
);

    localparam int               CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    ar_state_e          state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   outstanding [NUM_REQ];
    logic [NUM_REQ-1:0] eligible, win_oh, cnt_inc, cnt_dec;
    logic [IDX_W-1:0]   win_idx, r_idx;
    logic               any_elig, grant, r_last_hs;

    logic [ADDR_W-1:0]      req_addr  [NUM_REQ];
    logic [AXI_LEN_W-1:0]   req_len   [NUM_REQ];
    logic [AXI_SIZE_W-1:0]  req_size  [NUM_REQ];
    logic [AXI_BURST_W-1:0] req_burst [NUM_REQ];
    logic [ID_W-1:0]        req_id    [NUM_REQ];

    // ---------------- AR side ----------------
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_addr[i]  = s_araddr[i*ADDR_W +: ADDR_W];
        assign req_len[i]   = s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
        assign req_size[i]  = s_arsize[i*AXI_SIZE_W +: AXI_SIZE_W];
        assign req_burst[i] = s_arburst[i*AXI_BURST_W +: AXI_BURST_W];
        assign req_id[i]    = s_arid[i*ID_W +: ID_W];
        // A requester at its cap is simply not eligible, so the picker
        // moves on to the next one instead of stalling.
        assign eligible[i]  = s_arvalid[i] && (outstanding[i] < CNT_MAX);
        assign cnt_inc[i]   = grant && win_oh[i];
        // Never decrement from zero; that case raises err_unexpected_r.
        assign cnt_dec[i]   = r_last_hs && (r_idx == IDX_W'(i)) &&
                              (outstanding[i] != '0);
    end

    tcnt_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .any_valid (any_elig)
    );

    assign grant     = (state == ST_IDLE) && any_elig;
    assign s_arready = grant ? win_oh : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arid    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (grant) begin
                    m_arvalid <= 1'b1;
                    m_araddr  <= req_addr[win_idx];
                    m_arlen   <= req_len[win_idx];
                    m_arsize  <= req_size[win_idx];
                    m_arburst <= req_burst[win_idx];
                    m_arid    <= {win_idx, req_id[win_idx]};
                    rr_ptr    <= win_idx + 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- R side ----------------
    assign r_idx     = m_rid[ID_W +: IDX_W];
    assign m_rready  = s_rready[r_idx];
    assign s_rid     = m_rid[ID_W-1:0];
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign r_last_hs = m_rvalid && m_rready && m_rlast;

    always_comb begin
        s_rvalid        = '0;
        s_rvalid[r_idx] = m_rvalid;
    end

    // Grant and last beat for the same requester cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i])
                    outstanding[i] <= outstanding[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i])
                    outstanding[i] <= outstanding[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            err_unexpected_r <= 1'b0;
        else if (r_last_hs && (outstanding[r_idx] == '0))
            err_unexpected_r <= 1'b1;
    end

endmodule
